// File: rtl/tx_rs_fault_sequencer_if.sv
// MAC-side input and RS-IO-side output bundle of the TX fault sequencer.
// The master drives MAC data and link status; the slave (sequencer) drives the XGMII TX word.
interface tx_rs_fault_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       link_fault;
    logic [63:0]      txd64_in;
    logic [7:0]       txc8_in;
    logic [63:0]      txd64;
    logic [7:0]       txc8;
    logic             fault_active;
    logic [CNT_W-1:0] frames_dropped;

    modport master (
        output link_fault, txd64_in, txc8_in,
        input  txd64, txc8, fault_active, frames_dropped
    );

    modport slave (
        input  link_fault, txd64_in, txc8_in,
        output txd64, txc8, fault_active, frames_dropped
    );
endinterface

// File: rtl/tx_rs_fault_sequencer.sv
// TX RS fault sequencer: picks MAC data, Remote Fault or Idle per link_fault, switching only at frame boundaries.
// Latency 1 cycle input->txd64/txc8; no backpressure (free-running XGMII stream, dropped frames are counted).
module tx_rs_fault_sequencer #(
    parameter int RECOVER_COLS = 16,
    parameter int CNT_W        = 16
) (
    input  logic                   txclk,
    input  logic                   reset,
    tx_rs_fault_sequencer_if.slave bus
);
    localparam logic [2:0] ST_NORMAL_WAIT = 3'd0;
    localparam logic [2:0] ST_NORMAL      = 3'd1;
    localparam logic [2:0] ST_DRAIN       = 3'd2;
    localparam logic [2:0] ST_SEND_RF     = 3'd3;
    localparam logic [2:0] ST_SEND_IDLE   = 3'd4;
    localparam logic [2:0] ST_RECOVER     = 3'd5;

    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [7:0]  IDLE_C = 8'hFF;
    localparam logic [63:0] RF_D   = 64'h0200009C_0200009C;
    localparam logic [7:0]  RF_C   = 8'h11;

    localparam int           RW       = (RECOVER_COLS > 2) ? $clog2(RECOVER_COLS) : 1;
    localparam logic [RW-1:0] REC_LAST = RW'(RECOVER_COLS - 2);

    logic [2:0]       state_q, state_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic             in_frame_q, in_frame_d;
    logic [63:0]      txd_q, txd_d;
    logic [7:0]       txc_q, txc_d;
    logic             fa_q, fa_d;
    logic [CNT_W-1:0] drops_q, drops_d;
    logic             sof, eof, fault;
    logic [2:0]       fault_st;

    assign sof = (bus.txd64_in[7:0]   == 8'hFB && bus.txc8_in[0]) ||
                 (bus.txd64_in[39:32] == 8'hFB && bus.txc8_in[4]);

    always_comb begin
        eof = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.txd64_in[8*i +: 8] == 8'hFD && bus.txc8_in[i]) eof = 1'b1;
        end
    end

    // Terminate wins over start in the same word, so a one-word frame leaves in_frame clear.
    assign in_frame_d = eof ? 1'b0 : (sof ? 1'b1 : in_frame_q);
    assign fault      = (bus.link_fault != 2'b00);
    assign fault_st   = (bus.link_fault == 2'b10) ? ST_SEND_IDLE : ST_SEND_RF;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_NORMAL_WAIT: begin
                if (fault)                     state_d = fault_st;
                else if (!in_frame_q && !sof)  state_d = ST_NORMAL;
            end
            ST_NORMAL: begin
                if (fault) state_d = in_frame_d ? ST_DRAIN : fault_st;
            end
            ST_DRAIN: begin
                if (!in_frame_d) state_d = fault ? fault_st : ST_NORMAL;
            end
            ST_SEND_RF, ST_SEND_IDLE: begin
                if (fault) begin
                    state_d = fault_st;
                end else begin
                    state_d = ST_RECOVER;
                    rcnt_d  = '0;
                end
            end
            ST_RECOVER: begin
                if (fault) begin
                    state_d = fault_st;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                    if (rcnt_q == REC_LAST) state_d = ST_NORMAL_WAIT;
                end
            end
            default: state_d = ST_NORMAL_WAIT;
        endcase
    end

    always_comb begin
        txd_d = IDLE_D;
        txc_d = IDLE_C;
        case (state_q)
            ST_NORMAL, ST_DRAIN: begin
                txd_d = bus.txd64_in;
                txc_d = bus.txc8_in;
            end
            ST_SEND_RF: begin
                txd_d = RF_D;
                txc_d = RF_C;
            end
            default: ;
        endcase
    end

    // Any start seen while MAC data is not being passed means that whole frame is suppressed.
    always_comb begin
        drops_d = drops_q;
        if ((state_q inside {ST_NORMAL_WAIT, ST_SEND_RF, ST_SEND_IDLE, ST_RECOVER}) &&
            sof && (drops_q != {CNT_W{1'b1}}))
            drops_d = drops_q + 1'b1;
    end

    assign fa_d = (state_d == ST_SEND_RF) || (state_d == ST_SEND_IDLE);

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_NORMAL_WAIT;
            rcnt_q     <= '0;
            in_frame_q <= 1'b0;
            txd_q      <= IDLE_D;
            txc_q      <= IDLE_C;
            fa_q       <= 1'b0;
            drops_q    <= '0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            in_frame_q <= in_frame_d;
            txd_q      <= txd_d;
            txc_q      <= txc_d;
            fa_q       <= fa_d;
            drops_q    <= drops_d;
        end
    end

    assign bus.txd64          = txd_q;
    assign bus.txc8           = txc_q;
    assign bus.fault_active   = fa_q;
    assign bus.frames_dropped = drops_q;
endmodule

// File: tb/tb_tx_rs_fault_sequencer.sv
// Randomized scoreboard bench for tx_rs_fault_sequencer against a frame-level reference model.
module tb_tx_rs_fault_sequencer;
    localparam int REC_COLS = 16;
    localparam int CW       = 4;
    localparam int DMAX     = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tx_rs_fault_sequencer_if #(.CNT_W(CW)) bus();

    tx_rs_fault_sequencer #(.RECOVER_COLS(REC_COLS), .CNT_W(CW)) dut (
        .txclk (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [63:0]   d;
        logic [7:0]    c;
        logic          fa;
        logic [CW-1:0] drops;
    } exp_t;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
    } word_t;

    typedef enum int {M_WAIT, M_PASS, M_DRAIN, M_RF, M_RIDLE, M_RECOVER} mode_t;

    exp_t  sb[$];
    word_t gen_q[$];
    int    checks = 0;
    int    errors = 0;

    mode_t m_mode;
    bit    m_in_frame;
    int    m_left;
    int    m_drops;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = M_WAIT;
        m_in_frame = 1'b0;
        m_left     = 0;
        m_drops    = 0;
    endtask

    function automatic mode_t fault_mode(input logic [1:0] lf);
        return (lf == 2'b10) ? M_RIDLE : M_RF;
    endfunction

    // One MAC frame (start in lane 0 or 4, terminate at a random lane) followed by an idle gap.
    task automatic gen_frame();
        int    len, first, tl, gap;
        word_t w;
        len   = $urandom_range(1, 8);
        first = ($urandom_range(0, 3) == 0) ? 4 : 0;
        for (int k = 0; k < len; k++) begin
            w.d = {$urandom, $urandom};
            w.c = '0;
            if (k == 0) begin
                for (int i = 0; i < first; i++) begin
                    w.d[8*i +: 8] = 8'h07;
                    w.c[i]        = 1'b1;
                end
                w.d[8*first +: 8] = 8'hFB;
                w.c[first]        = 1'b1;
            end
            if (k == len - 1) begin
                tl = (k == 0) ? $urandom_range(first + 1, 7) : $urandom_range(0, 7);
                for (int i = tl; i < 8; i++) begin
                    w.d[8*i +: 8] = (i == tl) ? 8'hFD : 8'h07;
                    w.c[i]        = 1'b1;
                end
            end
            gen_q.push_back(w);
        end
        gap = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 24) : $urandom_range(0, 3);
        for (int k = 0; k < gap; k++) gen_q.push_back({64'h0707070707070707, 8'hFF});
    endtask

    // Reference: what the RS must emit one column later for this MAC word and link status.
    task automatic model_step(input word_t w, input logic [1:0] lf);
        bit   sof, eof, nxt_if;
        exp_t e;
        sof = (w.d[7:0] == 8'hFB && w.c[0]) || (w.d[39:32] == 8'hFB && w.c[4]);
        eof = 1'b0;
        for (int i = 0; i < 8; i++) if (w.d[8*i +: 8] == 8'hFD && w.c[i]) eof = 1'b1;

        if (m_mode == M_PASS || m_mode == M_DRAIN) begin
            e.d = w.d;                   e.c = w.c;
        end else if (m_mode == M_RF) begin
            e.d = 64'h0200009C_0200009C; e.c = 8'h11;
        end else begin
            e.d = 64'h0707070707070707;  e.c = 8'hFF;
        end

        if ((m_mode inside {M_WAIT, M_RF, M_RIDLE, M_RECOVER}) && sof && m_drops < DMAX) m_drops++;
        nxt_if = eof ? 1'b0 : (sof ? 1'b1 : m_in_frame);

        case (m_mode)
            M_WAIT:  if (lf != 2'b00) m_mode = fault_mode(lf);
                     else if (!m_in_frame && !sof) m_mode = M_PASS;
            M_PASS:  if (lf != 2'b00) m_mode = nxt_if ? M_DRAIN : fault_mode(lf);
            M_DRAIN: if (!nxt_if) m_mode = (lf != 2'b00) ? fault_mode(lf) : M_PASS;
            M_RF, M_RIDLE: begin
                if (lf != 2'b00) m_mode = fault_mode(lf);
                else begin
                    m_mode = M_RECOVER;
                    m_left = REC_COLS - 1;
                end
            end
            default: begin
                if (lf != 2'b00) m_mode = fault_mode(lf);
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_WAIT;
                end
            end
        endcase
        m_in_frame = nxt_if;

        e.fa    = (m_mode == M_RF) || (m_mode == M_RIDLE);
        e.drops = m_drops[CW-1:0];
        sb.push_back(e);
    endtask

    task automatic drive(input logic [1:0] lf);
        word_t w;
        @(negedge clk);
        if (gen_q.size() == 0) gen_frame();
        w = gen_q.pop_front();
        bus.txd64_in   = w.d;
        bus.txc8_in    = w.c;
        bus.link_fault = lf;
        model_step(w, lf);
    endtask

    task automatic hold(input logic [1:0] lf, input int n);
        for (int k = 0; k < n; k++) drive(lf);
    endtask

    task automatic wait_in_frame();
        int n;
        n = 0;
        while (!(m_mode == M_PASS && m_in_frame) && n < 3000) begin
            drive(2'b00);
            n++;
        end
        if (!(m_mode == M_PASS && m_in_frame)) begin
            checks++;
            errors++;
            $display("FAIL wait_in_frame: no frame in progress after %0d cycles, required one", n);
        end
    endtask

    task automatic random_phases(input int n);
        int          r;
        logic [1:0]  lf;
        for (int p = 0; p < n; p++) begin
            r  = $urandom_range(0, 9);
            lf = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r == 7) ? 2'b11 : 2'b10;
            hold(lf, $urandom_range(1, 40));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_txd64"},          bus.txd64,          64'h0707070707070707);
        chk({tag, "_txc8"},           bus.txc8,           64'hFF);
        chk({tag, "_fault_active"},   bus.fault_active,   64'h0);
        chk({tag, "_frames_dropped"}, bus.frames_dropped, 64'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                chk("txd64",          bus.txd64,          e.d);
                chk("txc8",           bus.txc8,           e.c);
                chk("fault_active",   bus.fault_active,   e.fa);
                chk("frames_dropped", bus.frames_dropped, e.drops);
            end
        end
    end

    initial begin : stimulus
        bus.link_fault = 2'b00;
        bus.txd64_in   = 64'h0707070707070707;
        bus.txc8_in    = 8'hFF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;

        hold(2'b00, 150);

        // Local fault arriving mid-frame must drain the frame before RF.
        wait_in_frame();
        hold(2'b01, 40);
        hold(2'b00, 60);

        // RF -> Idle switch, then the recovery window.
        hold(2'b01, 5);
        hold(2'b10, 5);
        hold(2'b00, 60);

        // Fault reappears mid-recovery, then a full recovery again.
        hold(2'b01, 5);
        hold(2'b00, 11);
        hold(2'b01, 3);
        hold(2'b00, 60);

        // Long fault with many MAC frames to exercise drop counting and saturation.
        hold(2'b11, 200);
        hold(2'b00, 40);

        random_phases(50);

        // Asynchronous reset in the middle of a passed frame.
        wait_in_frame();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        gen_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        hold(2'b00, 50);
        random_phases(30);
        hold(2'b00, 40);

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
